// File: rtl/mapper_mem_pkg.sv
// Shared types and constants for the mapper-to-memory arbiter.
package mapper_mem_pkg;

    // Width of a mapped PRG/CHR address.
    localparam int ADDR_W = 22;

    // Bit in flags_out that marks a PRG access as targeting mapper registers.
    localparam int FLAG_PRG_BUS_WRITE = 1;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRG_ACC = 2'd1,
        CHR_ACC = 2'd2
    } state_e;

    // Which side received the most recent grant. This is used for tie alternation.
    typedef enum logic {
        GRANT_PRG = 1'b0,
        GRANT_CHR = 1'b1
    } grant_e;

    // One captured memory access.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [7:0]        wdata;
    } access_t;

endpackage

// File: rtl/mem_req_slot.sv
// One pending-access slot. A new capture overwrites the stored access
// (newest wins). When set and clear arrive together, set wins. This way an
// access that arrives while the slot is being granted is kept pending.
module mem_req_slot
    import mapper_mem_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    set_i,
    input  access_t acc_i,
    input  logic    clr_i,
    output logic    pend_o,
    output access_t acc_o
);

    logic    pend_q, pend_d;
    access_t acc_q,  acc_d;

    // Next-state: set has priority over clear; a clear leaves the stored payload alone.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, otherwise a latch is inferred.
        pend_d = pend_q;
        acc_d  = acc_q;
        if (set_i) begin
            pend_d = 1'b1;
            acc_d  = acc_i;
        end else if (clr_i) begin
            pend_d = 1'b0;
        end
    end

    // Slot registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (reset) begin
            pend_q <= 1'b0;
            acc_q  <= '0;
        end else begin
            pend_q <= pend_d;
            acc_q  <= acc_d;
        end
    end

    assign pend_o = pend_q;
    assign acc_o  = acc_q;

endmodule

// File: rtl/mapper_mem_arbiter.sv
// Arbitrates mapped CPU (PRG) and PPU (CHR) accesses onto one external
// memory port that uses a req/ack handshake. Mapper register reads and
// open-bus reads are served locally without using memory.
module mapper_mem_arbiter
    import mapper_mem_pkg::*;
#(
    parameter int         TIMEOUT       = 64,
    parameter logic [7:0] OPEN_BUS_INIT = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic [ADDR_W-1:0] prg_aout,
    input  logic              prg_read,
    input  logic              prg_write,
    input  logic [7:0]        prg_din,
    input  logic              prg_allow,
    input  logic [7:0]        prg_dout,
    input  logic [15:0]       flags_out,
    input  logic [ADDR_W-1:0] chr_aout,
    input  logic              chr_strobe,
    input  logic              chr_write,
    input  logic [7:0]        chr_wdata,
    input  logic              chr_allow,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        cpu_data,
    output logic [7:0]        ppu_data,
    output logic              cpu_busy,
    output logic              timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    // Only the bus-write flag matters to this block.
    logic unused_flags;
    assign unused_flags = ^{flags_out[15:FLAG_PRG_BUS_WRITE+1], flags_out[FLAG_PRG_BUS_WRITE-1:0]};

    // ---------------- capture qualification ----------------
    logic cpu_cap, bus_reg, reg_read, prg_set, chr_set;
    assign cpu_cap  = ce & (prg_read | prg_write);
    assign bus_reg  = flags_out[FLAG_PRG_BUS_WRITE];
    assign reg_read = cpu_cap & prg_read & bus_reg;
    // Mapper-register ops, disallowed reads (open bus) and disallowed writes never reach memory.
    assign prg_set  = cpu_cap & ~bus_reg & prg_allow;
    // A CHR write that the mapper does not permit becomes a no-op.
    assign chr_set  = chr_strobe & ~(chr_write & ~chr_allow);

    access_t prg_new, chr_new, prg_acc, chr_acc;
    assign prg_new = '{addr: prg_aout, we: prg_write, wdata: prg_din};
    assign chr_new = '{addr: chr_aout, we: chr_write, wdata: chr_wdata};

    logic prg_pend, chr_pend, prg_clr, chr_clr;

    mem_req_slot u_prg_slot (
        .clk    (clk),
        .reset  (reset),
        .set_i  (prg_set),
        .acc_i  (prg_new),
        .clr_i  (prg_clr),
        .pend_o (prg_pend),
        .acc_o  (prg_acc)
    );

    mem_req_slot u_chr_slot (
        .clk    (clk),
        .reset  (reset),
        .set_i  (chr_set),
        .acc_i  (chr_new),
        .clr_i  (chr_clr),
        .pend_o (chr_pend),
        .acc_o  (chr_acc)
    );

    // ---------------- registers ----------------
    state_e            state_q,       state_d;
    grant_e            last_grant_q,  last_grant_d;
    logic [TW-1:0]     timer_q,       timer_d;
    logic              mem_req_q,     mem_req_d;
    logic              mem_we_q,      mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic [7:0]        mem_wdata_q,   mem_wdata_d;
    logic [7:0]        cpu_data_q,    cpu_data_d;
    logic [7:0]        ppu_data_q,    ppu_data_d;
    logic              cpu_busy_q,    cpu_busy_d;
    logic              timeout_err_q, timeout_err_d;

    logic grant_prg, prg_done;
    // On a tie, the side that did not win last time is granted.
    assign grant_prg = prg_pend & (~chr_pend | (last_grant_q == GRANT_CHR));

    // FSM, timer and data-return next-state logic.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        timer_d       = timer_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        cpu_data_d    = cpu_data_q;
        ppu_data_d    = ppu_data_q;
        timeout_err_d = timeout_err_q;
        prg_clr       = 1'b0;
        chr_clr       = 1'b0;
        prg_done      = 1'b0;

        case (state_q)
            IDLE: begin
                // A stray ack while idle is ignored.
                if (grant_prg) begin
                    state_d      = PRG_ACC;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = prg_acc.addr;
                    mem_we_d     = prg_acc.we;
                    mem_wdata_d  = prg_acc.wdata;
                    timer_d      = '0;
                    last_grant_d = GRANT_PRG;
                    prg_clr      = 1'b1;
                end else if (chr_pend) begin
                    state_d      = CHR_ACC;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = chr_acc.addr;
                    mem_we_d     = chr_acc.we;
                    mem_wdata_d  = chr_acc.wdata;
                    timer_d      = '0;
                    last_grant_d = GRANT_CHR;
                    chr_clr      = 1'b1;
                end
            end
            PRG_ACC, CHR_ACC: begin
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        if (state_q == PRG_ACC) cpu_data_d = mem_rdata;
                        else                    ppu_data_d = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    prg_done  = (state_q == PRG_ACC);
                    state_d   = IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    // Abort: reads return all-ones and the error flag becomes sticky.
                    if (!mem_we_q) begin
                        if (state_q == PRG_ACC) cpu_data_d = 8'hFF;
                        else                    ppu_data_d = 8'hFF;
                    end
                    mem_req_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    prg_done      = (state_q == PRG_ACC);
                    state_d       = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A mapper register read is the newest CPU operation, so it takes precedence.
        if (reg_read) cpu_data_d = prg_dout;
    end

    // CPU busy flag: set by a new capture, cleared when its access finishes with nothing queued.
    always_comb begin
        cpu_busy_d = cpu_busy_q;
        if (prg_set)                   cpu_busy_d = 1'b1;
        else if (prg_done && !prg_pend) cpu_busy_d = 1'b0;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_CHR;
            timer_q       <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cpu_data_q    <= OPEN_BUS_INIT;
            ppu_data_q    <= '0;
            cpu_busy_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            timer_q       <= timer_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            cpu_data_q    <= cpu_data_d;
            ppu_data_q    <= ppu_data_d;
            cpu_busy_q    <= cpu_busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cpu_data    = cpu_data_q;
    assign ppu_data    = ppu_data_q;
    assign cpu_busy    = cpu_busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mapper_mem_arbiter.sv
// Directed self-checking bench for mapper_mem_arbiter.
module tb_mapper_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic [21:0] prg_aout = '0;
    logic        prg_read = 1'b0;
    logic        prg_write = 1'b0;
    logic [7:0]  prg_din = '0;
    logic        prg_allow = 1'b0;
    logic [7:0]  prg_dout = '0;
    logic [15:0] flags_out = '0;
    logic [21:0] chr_aout = '0;
    logic        chr_strobe = 1'b0;
    logic        chr_write = 1'b0;
    logic [7:0]  chr_wdata = '0;
    logic        chr_allow = 1'b0;
    logic        mem_req, mem_we;
    logic [21:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  cpu_data, ppu_data;
    logic        cpu_busy, timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mapper_mem_arbiter #(.TIMEOUT(64), .OPEN_BUS_INIT(8'hFF)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .prg_aout(prg_aout), .prg_read(prg_read), .prg_write(prg_write),
        .prg_din(prg_din), .prg_allow(prg_allow), .prg_dout(prg_dout),
        .flags_out(flags_out),
        .chr_aout(chr_aout), .chr_strobe(chr_strobe), .chr_write(chr_write),
        .chr_wdata(chr_wdata), .chr_allow(chr_allow),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .cpu_data(cpu_data), .ppu_data(ppu_data),
        .cpu_busy(cpu_busy), .timeout_err(timeout_err)
    );

    // Advance past the next rising edge, then settle 1 ns for sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ce = 0; prg_read = 0; prg_write = 0; prg_allow = 0; flags_out = '0;
        chr_strobe = 0; chr_write = 0; chr_allow = 0; mem_ack = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b exp=0", mem_req); end
        n_cmp++; if (mem_addr !== 22'h0 || mem_we !== 1'b0 || mem_wdata !== 8'h00) begin n_bad++; $display("FAIL reset_mem got addr=%h we=%b wd=%h exp 0", mem_addr, mem_we, mem_wdata); end
        n_cmp++; if (cpu_data !== 8'hFF) begin n_bad++; $display("FAIL reset_cpu_data got=%h exp=FF", cpu_data); end
        n_cmp++; if (ppu_data !== 8'h00) begin n_bad++; $display("FAIL reset_ppu_data got=%h exp=00", ppu_data); end
        n_cmp++; if (cpu_busy !== 1'b0 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_flags got busy=%b terr=%b exp 0/0", cpu_busy, timeout_err); end
    endtask

    task automatic test_prg_read();
        ce = 1; prg_read = 1; prg_allow = 1; prg_aout = 22'h008123;
        tick();
        idle_inputs();
        n_cmp++; if (cpu_busy !== 1'b1) begin n_bad++; $display("FAIL prg_read_busy got=%b exp=1", cpu_busy); end
        tick();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr !== 22'h008123 || mem_we !== 1'b0) begin
                n_bad++; $display("FAIL prg_read_req[%0d] got req=%b addr=%h we=%b exp 1/008123/0", i, mem_req, mem_addr, mem_we);
            end
            if (i == 2) begin mem_ack = 1; mem_rdata = 8'h5A; end
            tick();
        end
        mem_ack = 0;
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL prg_read_req_drop got=%b exp=0", mem_req); end
        n_cmp++; if (cpu_data !== 8'h5A) begin n_bad++; $display("FAIL prg_read_data got=%h exp=5A", cpu_data); end
        n_cmp++; if (cpu_busy !== 1'b0) begin n_bad++; $display("FAIL prg_read_busy_clr got=%b exp=0", cpu_busy); end
    endtask

    task automatic test_reg_read();
        int reqs = 0;
        ce = 1; prg_read = 1; prg_allow = 1; flags_out = 16'h0002; prg_dout = 8'h3C; prg_aout = 22'h004000;
        tick();
        idle_inputs();
        n_cmp++; if (cpu_data !== 8'h3C) begin n_bad++; $display("FAIL reg_read_data got=%h exp=3C", cpu_data); end
        n_cmp++; if (cpu_busy !== 1'b0) begin n_bad++; $display("FAIL reg_read_busy got=%b exp=0", cpu_busy); end
        for (int i = 0; i < 5; i++) begin
            if (mem_req) reqs++;
            tick();
        end
        n_cmp++; if (reqs !== 0) begin n_bad++; $display("FAIL reg_read_noreq got=%0d req cycles exp=0", reqs); end
    endtask

    task automatic test_arbitration();
        do_reset();
        ce = 1; prg_read = 1; prg_allow = 1; prg_aout = 22'h00C000;
        chr_strobe = 1; chr_write = 0; chr_aout = 22'h201000;
        tick();
        idle_inputs();
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 22'h00C000) begin n_bad++; $display("FAIL arb_first got req=%b addr=%h exp 1/00C000", mem_req, mem_addr); end
        mem_ack = 1; mem_rdata = 8'h11;
        tick();
        mem_ack = 0;
        n_cmp++; if (mem_req !== 1'b0 || cpu_data !== 8'h11) begin n_bad++; $display("FAIL arb_gap got req=%b cpu=%h exp 0/11", mem_req, cpu_data); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 22'h201000 || mem_we !== 1'b0) begin n_bad++; $display("FAIL arb_second got req=%b addr=%h we=%b exp 1/201000/0", mem_req, mem_addr, mem_we); end
        mem_ack = 1; mem_rdata = 8'h22;
        tick();
        mem_ack = 0;
        n_cmp++; if (mem_req !== 1'b0 || ppu_data !== 8'h22) begin n_bad++; $display("FAIL arb_chr_done got req=%b ppu=%h exp 0/22", mem_req, ppu_data); end
    endtask

    task automatic test_timeout();
        int n = 0;
        chr_strobe = 1; chr_write = 0; chr_aout = 22'h000400;
        tick();
        idle_inputs();
        tick();
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL timeout_req_rise got=%b exp=1", mem_req); end
        while (mem_req === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        n_cmp++; if (n !== 64) begin n_bad++; $display("FAIL timeout_len got=%0d cycles exp=64", n); end
        n_cmp++; if (ppu_data !== 8'hFF) begin n_bad++; $display("FAIL timeout_ppu got=%h exp=FF", ppu_data); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err got=%b exp=1", timeout_err); end
        // A later successful access leaves the sticky error set.
        chr_strobe = 1; chr_aout = 22'h000401;
        tick();
        idle_inputs();
        tick();
        mem_ack = 1; mem_rdata = 8'h33;
        tick();
        mem_ack = 0;
        n_cmp++; if (timeout_err !== 1'b1 || ppu_data !== 8'h33) begin n_bad++; $display("FAIL timeout_sticky got terr=%b ppu=%h exp 1/33", timeout_err, ppu_data); end
    endtask

    task automatic test_prg_write();
        int reqs = 0;
        ce = 1; prg_write = 1; prg_allow = 0; prg_din = 8'hA5; prg_aout = 22'h000123;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            if (mem_req) reqs++;
            tick();
        end
        n_cmp++; if (reqs !== 0 || cpu_busy !== 1'b0) begin n_bad++; $display("FAIL wr_blocked got reqs=%0d busy=%b exp 0/0", reqs, cpu_busy); end
        n_cmp++; if (cpu_data !== 8'h11) begin n_bad++; $display("FAIL wr_open_bus got=%h exp=11", cpu_data); end
        ce = 1; prg_write = 1; prg_allow = 1; prg_din = 8'hA5; prg_aout = 22'h000123;
        tick();
        idle_inputs();
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 8'hA5 || mem_addr !== 22'h000123) begin
            n_bad++; $display("FAIL wr_req got req=%b we=%b wd=%h addr=%h exp 1/1/A5/000123", mem_req, mem_we, mem_wdata, mem_addr);
        end
        mem_ack = 1; mem_rdata = 8'h77;
        tick();
        mem_ack = 0;
        n_cmp++; if (mem_req !== 1'b0 || cpu_data !== 8'h11 || cpu_busy !== 1'b0) begin n_bad++; $display("FAIL wr_done got req=%b cpu=%h busy=%b exp 0/11/0", mem_req, cpu_data, cpu_busy); end
    endtask

    task automatic test_back_to_back();
        ce = 1; prg_read = 1; prg_allow = 1; prg_aout = 22'h000010;
        tick();
        // A new capture lands on the same edge that grants the first one.
        prg_aout = 22'h000020;
        tick();
        idle_inputs();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 22'h000010) begin n_bad++; $display("FAIL b2b_first got req=%b addr=%h exp 1/000010", mem_req, mem_addr); end
        mem_ack = 1; mem_rdata = 8'h44;
        tick();
        mem_ack = 0;
        n_cmp++; if (cpu_busy !== 1'b1 || cpu_data !== 8'h44) begin n_bad++; $display("FAIL b2b_busy got busy=%b cpu=%h exp 1/44", cpu_busy, cpu_data); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 22'h000020) begin n_bad++; $display("FAIL b2b_second got req=%b addr=%h exp 1/000020", mem_req, mem_addr); end
        mem_ack = 1; mem_rdata = 8'h55;
        tick();
        mem_ack = 0;
        n_cmp++; if (cpu_busy !== 1'b0 || cpu_data !== 8'h55) begin n_bad++; $display("FAIL b2b_done got busy=%b cpu=%h exp 0/55", cpu_busy, cpu_data); end
    endtask

    task automatic test_reset_mid();
        int reqs = 0;
        ce = 1; prg_read = 1; prg_allow = 1; prg_aout = 22'h000777;
        tick();
        idle_inputs();
        tick();
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre got req=%b exp=1", mem_req); end
        #2 reset = 1;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || cpu_data !== 8'hFF || cpu_busy !== 1'b0 || timeout_err !== 1'b0 || mem_addr !== 22'h0) begin
            n_bad++; $display("FAIL rst_mid_async got req=%b cpu=%h busy=%b terr=%b addr=%h exp 0/FF/0/0/0", mem_req, cpu_data, cpu_busy, timeout_err, mem_addr);
        end
        tick();
        reset = 0;
        mem_ack = 1; mem_rdata = 8'h99;
        tick();
        mem_ack = 0;
        n_cmp++; if (cpu_data !== 8'hFF) begin n_bad++; $display("FAIL rst_mid_late_ack got=%h exp=FF", cpu_data); end
        for (int i = 0; i < 5; i++) begin
            if (mem_req) reqs++;
            tick();
        end
        n_cmp++; if (reqs !== 0) begin n_bad++; $display("FAIL rst_mid_nogrant got=%0d req cycles exp=0", reqs); end
    endtask

    initial begin
        test_reset();
        test_prg_read();
        test_reg_read();
        test_arbitration();
        test_timeout();
        test_prg_write();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before bench completed");
        $fatal(1, "watchdog");
    end

endmodule
